// File: rtl/fpu_addsub_if.sv
// Request/response handshake bundle between the FPU issue logic and the add/sub sequencing stage.
interface fpu_addsub_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             req_mode;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_nv;
  logic             rsp_of;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_mode, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_nv, rsp_of, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_mode, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_nv, rsp_of, rsp_tag
  );
endinterface

// File: rtl/fpu_addsub_issue.sv
// FP32 add/sub sequencing stage: classifies operands, feeds the combinational datapath,
// resolves zero/Inf/NaN locally and holds the final result until the consumer takes it.
module fpu_addsub_issue #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fpu_addsub_if.slave      bus,
  output logic [31:0]      dp_a,
  output logic [31:0]      dp_b,
  output logic             dp_mode,
  output logic             dp_zero_a,
  output logic             dp_zero_b,
  input  logic [31:0]      dp_result,
  input  logic             dp_zero_sub,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;

  logic             req_ready, accept, rsp_fire;
  logic             sa, sb, za, zb, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
  logic [7:0]       ea, eb;
  logic [22:0]      fa, fb;
  logic             byp_c, byp_nv_c;
  logic [31:0]      byp_res_c;
  logic             byp_q, byp_nv_q;
  logic [31:0]      byp_res_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      res_c;
  logic             nv_c, of_c;
  logic [31:0]      rsp_result_q;
  logic             rsp_nv_q, rsp_of_q;
  logic [TAG_W-1:0] rsp_tag_q;

  assign req_ready = (state == IDLE) || (state == RESP && bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;
  assign rsp_fire  = (state == RESP) && bus.rsp_ready;

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_nv     = rsp_nv_q;
  assign bus.rsp_of     = rsp_of_q;
  assign bus.rsp_tag    = rsp_tag_q;

  // B is classified with its effective sign so subtraction is just addition of -B.
  assign sa     = bus.req_a[31];
  assign sb     = bus.req_b[31] ^ bus.req_mode;
  assign ea     = bus.req_a[30:23];
  assign eb     = bus.req_b[30:23];
  assign fa     = bus.req_a[22:0];
  assign fb     = bus.req_b[22:0];
  assign za     = (ea == 8'h00);
  assign zb     = (eb == 8'h00);
  assign inf_a  = (ea == 8'hFF) && (fa == '0);
  assign inf_b  = (eb == 8'hFF) && (fb == '0);
  assign nan_a  = (ea == 8'hFF) && (fa != '0);
  assign nan_b  = (eb == 8'hFF) && (fb != '0);
  assign snan_a = nan_a && !fa[22];
  assign snan_b = nan_b && !fb[22];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byp_c     = 1'b1;
    byp_nv_c  = 1'b0;
    byp_res_c = 32'h0000_0000;
    if (nan_a || nan_b) begin
      byp_res_c = 32'h7FC0_0000;
      byp_nv_c  = snan_a || snan_b;
    end else if (inf_a && inf_b && (sa != sb)) begin
      byp_res_c = 32'h7FC0_0000;
      byp_nv_c  = 1'b1;
    end else if (inf_a) begin
      byp_res_c = {sa, 8'hFF, 23'h0};
    end else if (inf_b) begin
      byp_res_c = {sb, 8'hFF, 23'h0};
    end else if (za && zb) begin
      byp_res_c = {sa & sb, 31'h0};
    end else if (za) begin
      byp_res_c = {sb, bus.req_b[30:0]};
    end else if (zb) begin
      byp_res_c = bus.req_a;
    end else begin
      byp_c = 1'b0;
    end
  end

  always_comb begin
    res_c = dp_result;
    nv_c  = 1'b0;
    of_c  = 1'b0;
    if (byp_q) begin
      res_c = byp_res_q;
      nv_c  = byp_nv_q;
    end else if (dp_zero_sub) begin
      res_c = 32'h0000_0000;
    end else if (dp_result[30:23] == 8'hFF) begin
      res_c = {dp_result[31], 8'hFF, 23'h0};
      of_c  = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = bus.req_valid ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      dp_a         <= '0;
      dp_b         <= '0;
      dp_mode      <= 1'b0;
      dp_zero_a    <= 1'b0;
      dp_zero_b    <= 1'b0;
      byp_q        <= 1'b0;
      byp_nv_q     <= 1'b0;
      byp_res_q    <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_nv_q     <= 1'b0;
      rsp_of_q     <= 1'b0;
      rsp_tag_q    <= '0;
      op_count     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dp_a      <= bus.req_a;
        dp_b      <= bus.req_b;
        dp_mode   <= bus.req_mode;
        dp_zero_a <= za;
        dp_zero_b <= zb;
        byp_q     <= byp_c;
        byp_nv_q  <= byp_nv_c;
        byp_res_q <= byp_res_c;
        tag_q     <= bus.req_tag;
      end
      if (state == EXEC) begin
        rsp_result_q <= res_c;
        rsp_nv_q     <= nv_c;
        rsp_of_q     <= of_c;
        rsp_tag_q    <= tag_q;
      end
      if (rsp_fire) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Directed bench for fpu_addsub_issue with a table-driven stand-in for the add/sub datapath.
module tb_fpu_addsub_issue;
  localparam int TAG_W = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      dp_a, dp_b, dp_result;
  logic             dp_mode, dp_zero_a, dp_zero_b, dp_zero_sub;
  logic [CNT_W-1:0] op_count;

  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_count = '0;

  fpu_addsub_if #(.TAG_W(TAG_W)) bus ();

  fpu_addsub_issue #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dp_a        (dp_a),
    .dp_b        (dp_b),
    .dp_mode     (dp_mode),
    .dp_zero_a   (dp_zero_a),
    .dp_zero_b   (dp_zero_b),
    .dp_result   (dp_result),
    .dp_zero_sub (dp_zero_sub),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  // Hand-computed sums for the finite operand pairs used below; anything else is junk.
  function automatic logic [32:0] dp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic m);
    if (!m && a == 32'h3F80_0000 && b == 32'h4000_0000) return {1'b0, 32'h4040_0000};
    if ( m && a == 32'h4040_0000 && b == 32'h4040_0000) return {1'b1, 32'h1234_5678};
    if (!m && a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) return {1'b0, 32'h7F80_0123};
    if (!m && a == 32'h3F80_0000 && b == 32'h3F80_0000) return {1'b0, 32'h4000_0000};
    if (!m && a == 32'h4000_0000 && b == 32'h4000_0000) return {1'b0, 32'h4080_0000};
    if (!m && a == 32'h4040_0000 && b == 32'h3F80_0000) return {1'b0, 32'h4080_0000};
    if ( m && a == 32'h3F80_0000 && b == 32'h4000_0000) return {1'b0, 32'hBF80_0000};
    return {1'b0, 32'hDEAD_BEEF};
  endfunction

  always_comb {dp_zero_sub, dp_result} = dp_model(dp_a, dp_b, dp_mode);

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = '0;
  endtask

  task automatic test_reset();
    bus.req_a = '0; bus.req_b = '0; bus.req_mode = 1'b0; bus.req_tag = '0;
    apply_reset();
    checks++;
    if ({bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_nv, bus.rsp_of, bus.rsp_tag} !==
        {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 5'h0}) begin
      errors++;
      $display("FAIL reset_rsp got valid=%b ready=%b res=%h nv=%b of=%b tag=%h", bus.rsp_valid,
               bus.req_ready, bus.rsp_result, bus.rsp_nv, bus.rsp_of, bus.rsp_tag);
    end
    checks++;
    if ({dp_a, dp_b, dp_mode, dp_zero_a, dp_zero_b, op_count} !== {64'h0, 3'b000, 16'h0}) begin
      errors++;
      $display("FAIL reset_dp got a=%h b=%h m=%b za=%b zb=%b cnt=%0d want all zero", dp_a, dp_b,
               dp_mode, dp_zero_a, dp_zero_b, op_count);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic m, input logic [TAG_W-1:0] tag, input logic [31:0] er,
                        input logic env, input logic eof);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_mode = m; bus.req_tag = tag;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready got %b want 1", name, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, dp_a, dp_b, dp_mode} !== {1'b0, a, b, m}) begin
      errors++;
      $display("FAIL %s exec got valid=%b dp_a=%h dp_b=%h mode=%b want 0 %h %h %b", name,
               bus.rsp_valid, dp_a, dp_b, dp_mode, a, b, m);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_nv, bus.rsp_of, bus.rsp_tag} !==
        {1'b1, er, env, eof, tag}) begin
      errors++;
      $display("FAIL %s rsp got v=%b res=%h nv=%b of=%b tag=%h want 1 %h %b %b %h", name,
               bus.rsp_valid, bus.rsp_result, bus.rsp_nv, bus.rsp_of, bus.rsp_tag, er, env, eof, tag);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    exp_count++;
    checks++;
    if (bus.rsp_valid !== 1'b0 || op_count !== exp_count) begin
      errors++;
      $display("FAIL %s handshake got valid=%b cnt=%0d want 0 %0d", name, bus.rsp_valid,
               op_count, exp_count);
    end
  endtask

  task automatic test_datapath();
    run_op("add_1p2",    32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd1, 32'h4040_0000, 1'b0, 1'b0);
    run_op("sub_cancel", 32'h4040_0000, 32'h4040_0000, 1'b1, 5'd2, 32'h0000_0000, 1'b0, 1'b0);
    run_op("overflow",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 5'd3, 32'h7F80_0000, 1'b0, 1'b1);
  endtask

  task automatic test_special();
    run_op("inf_m_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b1, 5'd4,  32'h7FC0_0000, 1'b1, 1'b0);
    run_op("inf_p_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b0, 5'd5,  32'h7F80_0000, 1'b0, 1'b0);
    run_op("snan",       32'h7F80_0001, 32'h3F80_0000, 1'b0, 5'd6,  32'h7FC0_0000, 1'b1, 1'b0);
    run_op("qnan",       32'h7FC0_0000, 32'h0000_0000, 1'b0, 5'd7,  32'h7FC0_0000, 1'b0, 1'b0);
    run_op("ninf_a",     32'hFF80_0000, 32'h3F80_0000, 1'b0, 5'd8,  32'hFF80_0000, 1'b0, 1'b0);
    run_op("one_m_inf",  32'h3F80_0000, 32'h7F80_0000, 1'b1, 5'd9,  32'hFF80_0000, 1'b0, 1'b0);
    run_op("nz_p_nz",    32'h8000_0000, 32'h8000_0000, 1'b0, 5'd10, 32'h8000_0000, 1'b0, 1'b0);
    run_op("nz_m_nz",    32'h8000_0000, 32'h8000_0000, 1'b1, 5'd11, 32'h0000_0000, 1'b0, 1'b0);
    run_op("denorm_a",   32'h0000_0001, 32'h3F80_0000, 1'b0, 5'd12, 32'h3F80_0000, 1'b0, 1'b0);
    run_op("denorm_b",   32'h4000_0000, 32'h0040_0000, 1'b1, 5'd13, 32'h4000_0000, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_a = 32'h3F80_0000; bus.req_b = 32'h4000_0000;
    bus.req_mode = 1'b0; bus.req_tag = 5'd20; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_b = 32'h3F80_0000; bus.req_tag = 5'd21;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_tag, dp_b} !==
          {1'b1, 1'b0, 32'h4040_0000, 5'd20, 32'h4000_0000}) begin
        errors++;
        $display("FAIL hold_%0d got v=%b rdy=%b res=%h tag=%h dp_b=%h", i, bus.rsp_valid,
                 bus.req_ready, bus.rsp_result, bus.rsp_tag, dp_b);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release_ready got %b want 1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    exp_count++;
    checks++;
    if ({bus.rsp_valid, dp_b, op_count} !== {1'b0, 32'h3F80_0000, exp_count}) begin
      errors++;
      $display("FAIL hold_reissue got v=%b dp_b=%h cnt=%0d want 0 3f800000 %0d", bus.rsp_valid,
               dp_b, op_count, exp_count);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_tag} !== {1'b1, 32'h4000_0000, 5'd21}) begin
      errors++;
      $display("FAIL hold_second got v=%b res=%h tag=%h want 1 40000000 15", bus.rsp_valid,
               bus.rsp_result, bus.rsp_tag);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000};
    logic [31:0] vb [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};
    logic        vm [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vr [4] = '{32'h4000_0000, 32'h4080_0000, 32'h4080_0000, 32'hBF80_0000};
    apply_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_a = va[0]; bus.req_b = vb[0]; bus.req_mode = vm[0];
    bus.req_tag = 5'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        bus.req_a = va[i+1]; bus.req_b = vb[i+1]; bus.req_mode = vm[i+1];
        bus.req_tag = 5'(i + 1);
      end else begin
        bus.req_valid = 1'b0;
      end
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_exec_%0d rsp_valid got %b want 0", i, bus.rsp_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_tag} !== {1'b1, vr[i], 5'(i)}) begin
        errors++;
        $display("FAIL b2b_rsp_%0d got v=%b res=%h tag=%h want 1 %h %h", i, bus.rsp_valid,
                 bus.rsp_result, bus.rsp_tag, vr[i], 5'(i));
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || op_count !== 16'd4) begin
      errors++;
      $display("FAIL b2b_count got v=%b cnt=%0d want 0 4", bus.rsp_valid, op_count);
    end
  endtask

  task automatic test_reset_exec();
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_a = 32'h3F80_0000; bus.req_b = 32'h4000_0000;
    bus.req_mode = 1'b0; bus.req_tag = 5'd30;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.rsp_valid, bus.req_ready, op_count, bus.rsp_result, dp_a} !==
        {1'b0, 1'b1, 16'd0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_exec got v=%b rdy=%b cnt=%0d res=%h dp_a=%h want 0 1 0 0 0",
               bus.rsp_valid, bus.req_ready, op_count, bus.rsp_result, dp_a);
    end
    rst_n = 1'b1;
    exp_count = '0;
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_exec_after got rsp_valid=%b want 0", bus.rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_datapath();
    test_special();
    test_hold();
    test_back_to_back();
    test_reset_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
